// File: rtl/crossbar_scheduler_if.sv
// FIFO-side and mux-side signals of the 3x3 byte-switch scheduler.
// master = scheduler, slave = switch top (FIFOs and select muxes).
interface crossbar_scheduler_if #(
    parameter int CNT_W = 8
);
    logic             enable;
    logic             empty1, empty2, empty3;
    logic [7:0]       data1, data2, data3;
    logic             rdreq1, rdreq2, rdreq3;
    logic [1:0]       sel1, sel2, sel3;
    logic [2:0]       out_valid;
    logic             busy;
    logic [CNT_W-1:0] drop_cnt;

    // rdreqN is a one-cycle pop strobe; dataN is valid the cycle after it and holds until the next pop.
    modport master (
        input  enable, empty1, empty2, empty3, data1, data2, data3,
        output rdreq1, rdreq2, rdreq3, sel1, sel2, sel3, out_valid, busy, drop_cnt
    );

    modport slave (
        output enable, empty1, empty2, empty3, data1, data2, data3,
        input  rdreq1, rdreq2, rdreq3, sel1, sel2, sel3, out_valid, busy, drop_cnt
    );
endinterface

// File: rtl/crossbar_scheduler.sv
// Pops input FIFO heads, decodes their destination and grants each output
// round-robin among contending inputs, holding the mux selects HOLD_CYCLES cycles.
module crossbar_scheduler #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    crossbar_scheduler_if.master  bus,
    output logic [2:0]            state_o
);
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_CAPT  = 3'd1,
        S_ALIGN = 3'd2,
        S_ARB   = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t            state_q;
    logic [2:0]        head_valid_q;
    logic [2:0][1:0]   dest_q;
    logic [2:0][1:0]   ptr_q;
    logic [2:0]        pop_q;
    logic [2:0]        win_q;
    logic [2:0][1:0]   sel_q;
    logic [2:0]        out_valid_q;
    logic [HCW-1:0]    hold_q;
    logic [CNT_W-1:0]  drop_cnt_q;

    logic [2:0]        empty_w;
    logic [2:0][1:0]   dhead_w;
    logic [2:0]        pop_w;
    logic [2:0][1:0]   sel_d;
    logic [2:0]        win_mask_w;
    logic [1:0]        cand;
    logic [1:0]        ndrop_w;
    logic [CNT_W+1:0]  drop_sum_w;
    logic [CNT_W-1:0]  drop_cnt_d;

    assign empty_w = {bus.empty3, bus.empty2, bus.empty1};
    assign dhead_w = {bus.data3[7:6], bus.data2[7:6], bus.data1[7:6]};

    // Pop strobes are combinational so the FIFO sees them in the S_FETCH cycle itself.
    always_comb begin
        pop_w = '0;
        if (reset_i && state_q == S_FETCH && bus.enable) begin
            for (int i = 0; i < 3; i++) begin
                pop_w[i] = !head_valid_q[i] && !empty_w[i];
            end
        end
    end

    // Scan from the candidate furthest from ptr backwards so the last hit is the first in RR order.
    always_comb begin
        sel_d      = '0;
        win_mask_w = '0;
        cand       = '0;
        for (int o = 0; o < 3; o++) begin
            for (int k = 3; k >= 1; k--) begin
                cand = 2'((int'(ptr_q[o]) + k - 1) % 3);
                if (head_valid_q[cand] && dest_q[cand] == 2'(o + 1)) begin
                    sel_d[o] = cand + 2'd1;
                end
            end
            if (sel_d[o] != 2'd0) begin
                win_mask_w[sel_d[o] - 2'd1] = 1'b1;
            end
        end
    end

    always_comb begin
        ndrop_w = '0;
        for (int i = 0; i < 3; i++) begin
            if (pop_q[i] && dhead_w[i] == 2'b00) begin
                ndrop_w = ndrop_w + 2'd1;
            end
        end
        drop_sum_w = {2'b00, drop_cnt_q} + (CNT_W+2)'(ndrop_w);
        drop_cnt_d = (drop_sum_w > {2'b00, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}}
                                                           : drop_sum_w[CNT_W-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= S_FETCH;
            head_valid_q <= '0;
            dest_q       <= '0;
            ptr_q        <= {3{2'd3}};
            pop_q        <= '0;
            win_q        <= '0;
            sel_q        <= '0;
            out_valid_q  <= '0;
            hold_q       <= '0;
            drop_cnt_q   <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    pop_q <= pop_w;
                    if (|pop_w) begin
                        state_q <= S_CAPT;
                    end else if (|head_valid_q) begin
                        state_q <= S_ARB;
                    end
                end
                S_CAPT: begin
                    for (int i = 0; i < 3; i++) begin
                        if (pop_q[i]) begin
                            dest_q[i]       <= dhead_w[i];
                            head_valid_q[i] <= (dhead_w[i] != 2'b00);
                        end
                    end
                    drop_cnt_q <= drop_cnt_d;
                    state_q    <= S_ALIGN;
                end
                S_ALIGN: begin
                    state_q <= S_ARB;
                end
                S_ARB: begin
                    sel_q <= sel_d;
                    win_q <= win_mask_w;
                    for (int o = 0; o < 3; o++) begin
                        out_valid_q[o] <= (sel_d[o] != 2'd0);
                        if (sel_d[o] != 2'd0) begin
                            ptr_q[o] <= sel_d[o];
                        end
                    end
                    if (|win_mask_w) begin
                        hold_q  <= HCW'(HOLD_CYCLES - 1);
                        state_q <= S_HOLD;
                    end else begin
                        state_q <= S_FETCH;
                    end
                end
                S_HOLD: begin
                    // Winners are retired only here; losers keep their heads for the next round.
                    if (hold_q == '0) begin
                        head_valid_q <= head_valid_q & ~win_q;
                        sel_q        <= '0;
                        out_valid_q  <= '0;
                        state_q      <= S_FETCH;
                    end else begin
                        hold_q <= hold_q - HCW'(1);
                    end
                end
                default: begin
                    state_q <= S_FETCH;
                end
            endcase
        end
    end

    assign bus.rdreq1    = pop_w[0];
    assign bus.rdreq2    = pop_w[1];
    assign bus.rdreq3    = pop_w[2];
    assign bus.sel1      = sel_q[0];
    assign bus.sel2      = sel_q[1];
    assign bus.sel3      = sel_q[2];
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != S_FETCH);
    assign bus.drop_cnt  = drop_cnt_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_crossbar_scheduler.sv
// Bench for crossbar_scheduler: FIFO models, a hold monitor, a vector table,
// hand-written corner sequences and random traffic against a round-level model.
module tb_crossbar_scheduler;
    localparam int HOLD  = 4;
    localparam int CNT_W = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] state_dbg;

    crossbar_scheduler_if #(.CNT_W(CNT_W)) bus ();

    crossbar_scheduler #(.HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
        .clk_i   (clk),
        .reset_i (reset_n),
        .bus     (bus),
        .state_o (state_dbg)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    logic [7:0] fq1[$], fq2[$], fq3[$];
    logic [7:0] mq1[$], mq2[$], mq3[$];
    logic [8:0] obs_q[$];
    int         len_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] exp_drops;

    typedef struct {
        logic [2:0] has;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [7:0] d3;
        int         holds;
        logic [8:0] first;
        logic [7:0] drops;
    } vec_t;

    vec_t vecs[8];

    // FIFO models: registered empty, q updated the edge after rdreq and held otherwise.
    always @(posedge clk) begin
        if (bus.rdreq1 && fq1.size() > 0) bus.data1 <= fq1.pop_front();
        if (bus.rdreq2 && fq2.size() > 0) bus.data2 <= fq2.pop_front();
        if (bus.rdreq3 && fq3.size() > 0) bus.data3 <= fq3.pop_front();
        bus.empty1 <= (fq1.size() == 0);
        bus.empty2 <= (fq2.size() == 0);
        bus.empty3 <= (fq3.size() == 0);
    end

    // Hold monitor: one record {out_valid, sel3, sel2, sel1} plus run length per grant.
    logic [8:0] run_val = '0;
    int         run_len = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            run_len = 0;
        end else if (bus.out_valid != 3'b000) begin
            if (run_len != 0 && {bus.out_valid, bus.sel3, bus.sel2, bus.sel1} != run_val) begin
                obs_q.push_back(run_val);
                len_q.push_back(run_len);
                run_len = 0;
            end
            if (run_len == 0) run_val = {bus.out_valid, bus.sel3, bus.sel2, bus.sel1};
            run_len++;
        end else if (run_len != 0) begin
            obs_q.push_back(run_val);
            len_q.push_back(run_len);
            run_len = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input int f, input logic [7:0] b);
        case (f)
            1: fq1.push_back(b);
            2: fq2.push_back(b);
            default: fq3.push_back(b);
        endcase
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.enable = 1'b0;
        reset_n = 1'b0;
        fq1.delete(); fq2.delete(); fq3.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        obs_q.delete(); len_q.delete();
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int quiet = 0;
        int n = 0;
        while (quiet < 6 && n < budget) begin
            @(negedge clk);
            n++;
            if (!bus.busy && fq1.size() == 0 && fq2.size() == 0 && fq3.size() == 0 &&
                bus.empty1 && bus.empty2 && bus.empty3) quiet++;
            else quiet = 0;
        end
        check({name, "_idle"}, 32'(quiet >= 6), 1);
    endtask

    task automatic wait_ov(input int budget, input string name);
        int n = 0;
        while (bus.out_valid == 3'b000 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_grant_seen"}, 32'(bus.out_valid != 3'b000), 1);
    endtask

    function automatic int model_size(input int f);
        case (f)
            0: return mq1.size();
            1: return mq2.size();
            default: return mq3.size();
        endcase
    endfunction

    function automatic logic [7:0] model_pop(input int f);
        case (f)
            0: return mq1.pop_front();
            1: return mq2.pop_front();
            default: return mq3.pop_front();
        endcase
    endfunction

    // Round-level model: refill empty heads, then each output picks the first
    // requesting input after its last winner; winners retire, losers wait.
    task automatic run_model();
        logic       hv[3];
        logic [1:0] hd[3];
        int         last[3];
        int         win[3];
        int         drops;
        int         c1;
        logic [7:0] b;
        drops = 0;
        for (int i = 0; i < 3; i++) begin hv[i] = 1'b0; hd[i] = 2'd0; last[i] = 3; end
        exp_q.delete();
        for (int r = 0; r < 300; r++) begin
            for (int i = 0; i < 3; i++) begin
                if (!hv[i] && model_size(i) > 0) begin
                    b = model_pop(i);
                    if (b[7:6] == 2'b00) drops++;
                    else begin hv[i] = 1'b1; hd[i] = b[7:6]; end
                end
            end
            if (!(hv[0] || hv[1] || hv[2])) begin
                if (model_size(0) + model_size(1) + model_size(2) == 0) break;
                continue;
            end
            for (int o = 0; o < 3; o++) begin
                win[o] = 0;
                for (int k = 1; k <= 3; k++) begin
                    c1 = (last[o] + k - 1) % 3 + 1;
                    if (win[o] == 0 && hv[c1-1] && int'(hd[c1-1]) == o + 1) win[o] = c1;
                end
                if (win[o] != 0) last[o] = win[o];
            end
            for (int o = 0; o < 3; o++) if (win[o] != 0) hv[win[o]-1] = 1'b0;
            exp_q.push_back({win[2] != 0, win[1] != 0, win[0] != 0,
                             2'(win[2]), 2'(win[1]), 2'(win[0])});
        end
        exp_drops = (drops > 255) ? 8'hFF : 8'(drops);
    endtask

    logic       rd_log[30];
    logic [2:0] ov_log[30];
    logic [1:0] s1_log[30];
    int         t4_exp[9];

    initial begin
        int t0, t1, rd_n, ov_n, rd_cnt, nf, nmin;
        logic [1:0] after;
        logic [7:0] b;

        vecs[0] = '{3'b001, 8'h45, 8'h00, 8'h00, 1, 9'b001_00_00_01, 8'd0};
        vecs[1] = '{3'b111, 8'h40, 8'h80, 8'hC0, 1, 9'b111_11_10_01, 8'd0};
        vecs[2] = '{3'b111, 8'h41, 8'h7F, 8'h55, 3, 9'b001_00_00_01, 8'd0};
        vecs[3] = '{3'b010, 8'h00, 8'h3F, 8'h00, 0, 9'b000_00_00_00, 8'd1};
        vecs[4] = '{3'b110, 8'h00, 8'hC1, 8'hF0, 2, 9'b100_10_00_00, 8'd0};
        vecs[5] = '{3'b111, 8'hC5, 8'h3F, 8'h81, 1, 9'b110_01_11_00, 8'd1};
        vecs[6] = '{3'b111, 8'h00, 8'h00, 8'h00, 0, 9'b000_00_00_00, 8'd3};
        vecs[7] = '{3'b101, 8'h80, 8'h00, 8'h45, 1, 9'b011_00_01_11, 8'd0};
        t4_exp = '{1, 2, 3, 1, 2, 3, 1, 2, 3};

        bus.enable = 1'b0;
        bus.data1 = '0; bus.data2 = '0; bus.data3 = '0;
        bus.empty1 = 1'b1; bus.empty2 = 1'b1; bus.empty3 = 1'b1;

        // Reset values
        do_reset();
        check("rst_sel", {bus.sel3, bus.sel2, bus.sel1}, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_drop_cnt", bus.drop_cnt, 0);
        check("rst_state", state_dbg, 0);

        // Single-round vector table
        for (int v = 0; v < 8; v++) begin
            do_reset();
            if (vecs[v].has[0]) push(1, vecs[v].d1);
            if (vecs[v].has[1]) push(2, vecs[v].d2);
            if (vecs[v].has[2]) push(3, vecs[v].d3);
            repeat (2) @(negedge clk);
            bus.enable = 1'b1;
            wait_idle(300, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_holds", v), obs_q.size(), vecs[v].holds);
            if (vecs[v].holds > 0 && obs_q.size() > 0) begin
                check($sformatf("vec%0d_first", v), obs_q[0], vecs[v].first);
                check($sformatf("vec%0d_len", v), len_q[0], HOLD);
            end
            check($sformatf("vec%0d_drops", v), bus.drop_cnt, vecs[v].drops);
        end

        // Single-transfer timing
        do_reset();
        push(1, 8'h45);
        repeat (2) @(negedge clk);
        bus.enable = 1'b1;
        for (int c = 0; c < 30; c++) begin
            #1;
            rd_log[c] = bus.rdreq1;
            ov_log[c] = bus.out_valid;
            s1_log[c] = bus.sel1;
            @(negedge clk);
        end
        t0 = -1; t1 = -1; rd_n = 0; ov_n = 0;
        for (int c = 0; c < 30; c++) begin
            if (rd_log[c]) begin rd_n++; if (t0 < 0) t0 = c; end
            if (ov_log[c] != 3'b000) begin ov_n++; if (t1 < 0) t1 = c; end
        end
        check("t2_rdreq_pulses", rd_n, 1);
        check("t2_latency", t1 - t0, 4);
        check("t2_out_valid", (t1 >= 0) ? ov_log[t1] : 3'b000, 3'b001);
        check("t2_sel1", (t1 >= 0) ? s1_log[t1] : 2'd0, 1);
        check("t2_hold_cycles", ov_n, HOLD);
        after = (t1 >= 0 && t1 + HOLD < 30) ? s1_log[t1+HOLD] : 2'd3;
        check("t2_sel1_released", after, 0);

        // Reset in the middle of a hold; popped heads are discarded
        do_reset();
        push(1, 8'h40); push(2, 8'h3F); push(2, 8'h80); push(3, 8'hC0);
        repeat (2) @(negedge clk);
        bus.enable = 1'b1;
        wait_ov(40, "t1");
        @(negedge clk);
        check("t1_pre_drop_cnt", bus.drop_cnt, 1);
        reset_n = 1'b0;
        #1;
        check("t1_sel", {bus.sel3, bus.sel2, bus.sel1}, 0);
        check("t1_out_valid", bus.out_valid, 0);
        check("t1_drop_cnt", bus.drop_cnt, 0);
        check("t1_busy", bus.busy, 0);
        check("t1_rdreq_in_reset", {bus.rdreq3, bus.rdreq2, bus.rdreq1}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        obs_q.delete(); len_q.delete();
        wait_idle(200, "t1_after");
        check("t1_after_holds", obs_q.size(), 1);
        if (obs_q.size() > 0) check("t1_after_grant", obs_q[0], 9'b010_00_10_00);
        check("t1_after_drops", bus.drop_cnt, 0);

        // Contention on output 2
        do_reset();
        for (int i = 0; i < 3; i++) begin push(1, 8'h80); push(2, 8'h81); push(3, 8'h82); end
        repeat (2) @(negedge clk);
        bus.enable = 1'b1;
        wait_idle(500, "t4");
        check("t4_holds", obs_q.size(), 9);
        nmin = (obs_q.size() < 9) ? obs_q.size() : 9;
        for (int k = 0; k < nmin; k++) begin
            check($sformatf("t4_round%0d", k), {obs_q[k][8:6], obs_q[k][3:2]},
                  {3'b010, 2'(t4_exp[k])});
        end

        // Drop counter saturation
        do_reset();
        for (int i = 0; i < 260; i++) push(2, 8'($urandom_range(0, 63)));
        repeat (2) @(negedge clk);
        bus.enable = 1'b1;
        wait_idle(3000, "t5");
        check("t5_drop_sat", bus.drop_cnt, 8'hFF);
        check("t5_no_grants", obs_q.size(), 0);

        // Enable low: finish the hold, then stop popping
        do_reset();
        push(1, 8'h45); push(1, 8'h46); push(1, 8'h47);
        repeat (2) @(negedge clk);
        bus.enable = 1'b1;
        wait_ov(40, "t6");
        @(negedge clk);
        bus.enable = 1'b0;
        rd_cnt = 0;
        repeat (30) begin
            @(negedge clk);
            rd_cnt += int'(bus.rdreq1 | bus.rdreq2 | bus.rdreq3);
        end
        check("t6_no_rdreq", rd_cnt, 0);
        check("t6_fifo_left", fq1.size(), 2);
        check("t6_idle", bus.busy, 0);
        check("t6_holds_before", obs_q.size(), 1);
        bus.enable = 1'b1;
        #1;
        check("t6_resume_rdreq", bus.rdreq1, 1);
        wait_idle(200, "t6_resume");
        check("t6_holds_total", obs_q.size(), 3);

        // Random traffic against the round-level model
        for (int it = 0; it < 4; it++) begin
            do_reset();
            mq1.delete(); mq2.delete(); mq3.delete();
            for (int f = 1; f <= 3; f++) begin
                nf = $urandom_range(1, 6);
                for (int j = 0; j < nf; j++) begin
                    b = 8'($urandom_range(0, 255));
                    push(f, b);
                    case (f)
                        1: mq1.push_back(b);
                        2: mq2.push_back(b);
                        default: mq3.push_back(b);
                    endcase
                end
            end
            run_model();
            repeat (2) @(negedge clk);
            bus.enable = 1'b1;
            wait_idle(1500, $sformatf("rnd%0d", it));
            check($sformatf("rnd%0d_holds", it), obs_q.size(), exp_q.size());
            nmin = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
            for (int k = 0; k < nmin; k++) begin
                check($sformatf("rnd%0d_grant%0d", it, k), obs_q[k], exp_q[k]);
                check($sformatf("rnd%0d_len%0d", it, k), len_q[k], HOLD);
            end
            check($sformatf("rnd%0d_drops", it), bus.drop_cnt, exp_drops);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
